// File: rtl/ebpc_pkg.sv
// Shared constants, FSM encoding and helpers for the bit packer.
package ebpc_pkg;

    localparam int DATA_W         = 8;
    localparam int LOG_DATA_W     = 3;
    localparam int MAX_CODE_W     = 16;
    localparam int LOG_MAX_CODE_W = 4;
    localparam int BUF_W          = MAX_CODE_W + DATA_W;
    localparam int FILL_W         = 5;

    localparam logic [FILL_W-1:0] FILL_DATA_W = FILL_W'(DATA_W);
    localparam logic [FILL_W-1:0] FILL_BUF_W  = FILL_W'(BUF_W);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } packer_state_e;

    // Ones in the low len bits; len may be the full MAX_CODE_W.
    function automatic logic [MAX_CODE_W-1:0] code_mask(input logic [LOG_MAX_CODE_W:0] len);
        logic [MAX_CODE_W:0] m;
        m = ((MAX_CODE_W+1)'(1) << len) - (MAX_CODE_W+1)'(1);
        return m[MAX_CODE_W-1:0];
    endfunction

endpackage

// File: rtl/packer.sv
// Packs variable-length codewords MSB-first into DATA_W-bit words; a word is valid the cycle after fill reaches DATA_W.
// Input is refused while a full word is buffered or during drain; outputs hold under rdy_i low, and rdy_o never depends on rdy_i.
module packer
    import ebpc_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [MAX_CODE_W-1:0]     data_i,
    input  logic [LOG_MAX_CODE_W:0]   len_i,
    input  logic                      last_i,
    input  logic                      vld_i,
    output logic                      rdy_o,
    output logic [DATA_W-1:0]         data_o,
    output logic                      last_o,
    output logic                      vld_o,
    input  logic                      rdy_i,
    input  logic                      clr_i
);

    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    packer_state_e     state_q, state_d;

    logic              in_hs, out_hs;
    logic [BUF_W-1:0]  pop_buf, app_bits;
    logic [FILL_W-1:0] pop_fill, shamt;

    // Handshake outputs come from registered state only.
    always_comb begin
        rdy_o  = 1'b0;
        vld_o  = 1'b0;
        last_o = 1'b0;
        case (state_q)
            RUN: begin
                rdy_o = (fill_q < FILL_DATA_W);
                vld_o = (fill_q >= FILL_DATA_W);
            end
            DRAIN: begin
                vld_o  = (fill_q != '0);
                last_o = (fill_q != '0) && (fill_q <= FILL_DATA_W);
            end
            default: ;
        endcase
    end

    assign data_o = buf_q[BUF_W-1 -: DATA_W];
    assign in_hs  = vld_i && rdy_o;
    assign out_hs = vld_o && rdy_i;

    always_comb begin
        pop_buf  = buf_q;
        pop_fill = fill_q;
        if (out_hs) begin
            pop_buf  = buf_q << DATA_W;
            pop_fill = (fill_q >= FILL_DATA_W) ? (fill_q - FILL_DATA_W) : '0;
        end

        // Append lands directly below the post-pop fill level.
        shamt    = FILL_BUF_W - pop_fill - len_i;
        app_bits = BUF_W'(data_i & code_mask(len_i)) << shamt;

        buf_d   = pop_buf;
        fill_d  = pop_fill;
        state_d = state_q;

        if (in_hs) begin
            buf_d  = pop_buf | app_bits;
            fill_d = pop_fill + len_i;
            if (state_q == RUN && last_i && (fill_d != '0)) begin
                state_d = DRAIN;
            end
        end

        if (state_q == DRAIN && out_hs && last_o) begin
            state_d = RUN;
            fill_d  = '0;
            buf_d   = '0;
        end

        if (clr_i) begin
            state_d = RUN;
            fill_d  = '0;
            buf_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_q   <= '0;
            fill_q  <= '0;
            state_q <= RUN;
        end else begin
            buf_q   <= buf_d;
            fill_q  <= fill_d;
            state_q <= state_d;
        end
    end

    len_legal_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (vld_i && rdy_o) |-> (len_i <= (LOG_MAX_CODE_W+1)'(MAX_CODE_W)));

endmodule

// File: tb/tb_packer.sv
// Directed and randomised stimulus for the packer against hand-computed values and a bit-queue model.
module tb_packer;
    import ebpc_pkg::*;

    logic                    clk_i;
    logic                    rst_ni;
    logic [MAX_CODE_W-1:0]   data_i;
    logic [LOG_MAX_CODE_W:0] len_i;
    logic                    last_i;
    logic                    vld_i;
    logic                    rdy_o;
    logic [DATA_W-1:0]       data_o;
    logic                    last_o;
    logic                    vld_o;
    logic                    rdy_i;
    logic                    clr_i;

    int tests = 0;
    int fails = 0;

    packer dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .data_i (data_i),
        .len_i  (len_i),
        .last_i (last_i),
        .vld_i  (vld_i),
        .rdy_o  (rdy_o),
        .data_o (data_o),
        .last_o (last_o),
        .vld_o  (vld_o),
        .rdy_i  (rdy_i),
        .clr_i  (clr_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [15:0] d, input logic [4:0] l, input logic lst);
        vld_i  = 1'b1;
        data_i = d;
        len_i  = l;
        last_i = lst;
    endtask

    task automatic idle();
        vld_i  = 1'b0;
        last_i = 1'b0;
        data_i = '0;
        len_i  = '0;
    endtask

    localparam int N_CW = 60;

    initial begin : main
        logic          model_q[$];
        logic [15:0]   cw_d[N_CW];
        logic [4:0]    cw_l[N_CW];
        logic [7:0]    exp_w;
        logic          exp_last;
        int            idx;
        int            cyc;
        int            qsz;
        bit            sent_last;
        bit            done;

        rst_ni = 1'b0;
        rdy_i  = 1'b0;
        clr_i  = 1'b0;
        idle();
        #12;
        check("rst_rdy",  rdy_o, 1);
        check("rst_vld",  vld_o, 0);
        check("rst_last", last_o, 0);
        check("rst_data", data_o, 0);
        check("rst_fill", dut.fill_q, 0);
        step();
        rst_ni = 1'b1;
        rdy_i  = 1'b1;
        step();

        // Two codewords form exactly one word.
        drive(16'h0005, 5'd3, 1'b0);
        step();
        check("b9_fill3", dut.fill_q, 3);
        check("b9_vld_early", vld_o, 0);
        drive(16'h0019, 5'd5, 1'b0);
        step();
        check("b9_vld", vld_o, 1);
        check("b9_data", data_o, 8'hB9);
        check("b9_last", last_o, 0);
        check("b9_rdy", rdy_o, 0);
        idle();
        step();
        check("b9_popped_vld", vld_o, 0);
        check("b9_popped_rdy", rdy_o, 1);

        // Full-width codeword with upper junk absent: two back-to-back words.
        drive(16'hABCD, 5'd16, 1'b0);
        step();
        idle();
        check("abcd_w0", data_o, 8'hAB);
        check("abcd_rdy0", rdy_o, 0);
        step();
        check("abcd_w1", data_o, 8'hCD);
        check("abcd_vld1", vld_o, 1);
        check("abcd_rdy1", rdy_o, 0);
        step();
        check("abcd_empty", vld_o, 0);
        check("abcd_rdy2", rdy_o, 1);

        // Short final codeword is zero-padded and flagged last.
        drive(16'hFFFD, 5'd3, 1'b1);
        step();
        idle();
        check("a0_state", dut.state_q, DRAIN);
        check("a0_data", data_o, 8'hA0);
        check("a0_last", last_o, 1);
        check("a0_rdy", rdy_o, 0);
        step();
        check("a0_state_run", dut.state_q, RUN);
        check("a0_rdy_after", rdy_o, 1);
        check("a0_vld_after", vld_o, 0);

        // Empty last codeword on an empty buffer emits nothing.
        drive(16'hFFFF, 5'd0, 1'b1);
        step();
        idle();
        check("len0_state", dut.state_q, RUN);
        check("len0_vld", vld_o, 0);
        check("len0_fill", dut.fill_q, 0);

        // Backpressure hold with fill 12.
        rdy_i = 1'b0;
        drive(16'h0ABC, 5'd12, 1'b0);
        step();
        idle();
        for (int i = 0; i < 5; i++) begin
            check("hold_data", data_o, 8'hAB);
            check("hold_vld", vld_o, 1);
            check("hold_rdy", rdy_o, 0);
            step();
        end
        rdy_i = 1'b1;
        step();
        check("rel_fill", dut.fill_q, 4);
        check("rel_rdy", rdy_o, 1);
        check("rel_vld", vld_o, 0);
        check("rel_data", data_o, 8'hC0);

        // Reach DRAIN with fill 10, then clear while a pop would be accepted.
        rdy_i = 1'b0;
        drive(16'h003F, 5'd6, 1'b1);
        step();
        idle();
        check("dr_state", dut.state_q, DRAIN);
        check("dr_fill", dut.fill_q, 10);
        check("dr_data", data_o, 8'hCF);
        check("dr_last", last_o, 0);
        rdy_i = 1'b1;
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        check("clr_vld", vld_o, 0);
        check("clr_rdy", rdy_o, 1);
        check("clr_fill", dut.fill_q, 0);
        check("clr_state", dut.state_q, RUN);
        drive(16'h005A, 5'd8, 1'b0);
        step();
        idle();
        check("post_clr_data", data_o, 8'h5A);
        check("post_clr_vld", vld_o, 1);
        step();

        // Reset mid-stream drops buffered bits.
        drive(16'h0007, 5'd3, 1'b0);
        step();
        idle();
        rst_ni = 1'b0;
        #2;
        check("mid_rst_fill", dut.fill_q, 0);
        check("mid_rst_rdy", rdy_o, 1);
        step();
        rst_ni = 1'b1;
        drive(16'h001F, 5'd5, 1'b0);
        step();
        idle();
        check("post_rst_fill", dut.fill_q, 5);
        check("post_rst_vld", vld_o, 0);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;

        // Random stream against a bit-queue model.
        for (int i = 0; i < N_CW; i++) begin
            cw_d[i] = 16'($urandom());
            cw_l[i] = 5'($urandom_range(0, 16));
        end
        cw_l[N_CW-1] = 5'($urandom_range(1, 16));
        idx = 0;
        cyc = 0;
        sent_last = 1'b0;
        done = 1'b0;
        while (!done && cyc < 3000) begin
            cyc++;
            rdy_i = ($urandom_range(0, 3) != 0);
            if (idx < N_CW && $urandom_range(0, 4) != 0) begin
                drive(cw_d[idx], cw_l[idx], (idx == N_CW-1));
            end else begin
                idle();
            end
            if (vld_o && rdy_i) begin
                qsz = model_q.size();
                exp_last = sent_last && (qsz <= DATA_W);
                exp_w = '0;
                for (int k = 0; k < DATA_W; k++) begin
                    if (model_q.size() > 0) exp_w = {exp_w[6:0], model_q.pop_front()};
                    else                    exp_w = {exp_w[6:0], 1'b0};
                end
                check("rnd_data", data_o, exp_w);
                check("rnd_last", last_o, exp_last);
                if (exp_last) done = 1'b1;
            end
            if (vld_i && rdy_o) begin
                for (int k = 15; k >= 0; k--) begin
                    if (k < int'(len_i)) model_q.push_back(data_i[k]);
                end
                if (last_i) sent_last = 1'b1;
                idx++;
            end
            step();
        end
        idle();
        check("rnd_done", done, 1);
        check("rnd_all_sent", idx, N_CW);
        check("rnd_state", dut.state_q, RUN);
        check("rnd_rdy", rdy_o, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/packer.md
PACKER -- requirements
Module: packer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk_i and rst_ni.
REQ-002 Parameters SHALL come from ebpc_pkg: DATA_W = 8 (output word width) and MAX_CODE_W = 16 (max codeword length). Derived constants: LOG_MAX_CODE_W = 4 and BUF_W = MAX_CODE_W + DATA_W = 24.
REQ-003 Ports, one per line:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
data_i  in  MAX_CODE_W  codeword, right-aligned; bits at or above len_i ignored
len_i  in  LOG_MAX_CODE_W+1  codeword length, 0..MAX_CODE_W
last_i  in  1  codeword ends the stream
vld_i  in  1  input valid
rdy_o  out  1  input ready
data_o  out  DATA_W  packed word, MSB = oldest bit
last_o  out  1  final word of the stream
vld_o  out  1  output valid
rdy_i  in  1  output ready
clr_i  in  1  synchronous clear

Function
REQ-004 Input handshake SHALL be vld_i && rdy_o; output handshake SHALL be vld_o && rdy_i.
REQ-005 State SHALL be: bit buffer buf_q[BUF_W-1:0], MSB-aligned; fill counter fill_q (0..BUF_W); FSM state_q in {RUN, DRAIN}.
REQ-006 Append: on input handshake, the masked codeword SHALL be OR-ed into buf at bit positions [BUF_W-1-fill .. BUF_W-fill-len], MSB of codeword first; fill += len_i.
REQ-007 Pop: on output handshake, buf SHALL shift left by DATA_W with zero fill; fill = max(fill - DATA_W, 0).
REQ-008 Simultaneous pop and append SHALL act as pop first, then append at the post-pop fill, all in one cycle.
REQ-009 data_o SHALL equal buf_q[BUF_W-1 -: DATA_W]; unfilled low bits SHALL read zero (zero padding).
REQ-010 RUN: rdy_o = (fill_q < DATA_W); vld_o = (fill_q >= DATA_W); last_o = 0. No combinational path from rdy_i to rdy_o.
REQ-011 RUN -> DRAIN when an input handshake carries last_i = 1 and post-update fill > 0.
REQ-012 If last_i is accepted with post-update fill = 0, the block SHALL stay in RUN and emit nothing.
REQ-013 DRAIN: rdy_o = 0; vld_o = (fill_q > 0); last_o = vld_o && (fill_q <= DATA_W).
REQ-014 DRAIN -> RUN on the output handshake where last_o = 1; fill SHALL become 0.
REQ-015 Under vld_o && !rdy_i, data_o and last_o SHALL hold stable.
REQ-016 len_i = 0 SHALL be accepted as a no-op append; last_i still applies.
REQ-017 len_i > MAX_CODE_W is illegal and SHALL be flagged by a simulation assertion.
REQ-018 Latency: a word SHALL become valid in the cycle after the handshake that brings fill to >= DATA_W; sustained throughput is up to one output word per cycle.
REQ-019 clr_i SHALL, on the next edge, set buf = 0, fill = 0, state = RUN, overriding any concurrent handshake.

Reset
REQ-020 While rst_ni = 0: buf_q = 0, fill_q = 0, state_q = RUN; outputs rdy_o = 1, vld_o = 0, last_o = 0, data_o = 0.
REQ-021 Reset asserted mid-stream SHALL discard all buffered bits; no partial word SHALL be emitted after release.

Structure
REQ-022 DATA_W, LOG_DATA_W, MAX_CODE_W, LOG_MAX_CODE_W and the FSM state enum packer_state_e SHALL reside in ebpc_pkg.
REQ-023 The block SHALL be a single module with no sub-modules; the append/shift datapath is inline.

Verification
REQ-024 (3'b101, len 3) then (5'b11001, len 5), rdy_i = 1 -> one word 0xB9, last_o = 0.
REQ-025 From empty, (0xABCD, len 16) -> 0xAB, then 0xCD on consecutive cycles; rdy_o = 0 while fill >= 8.
REQ-026 (3'b101, len 3, last_i = 1) -> one word 0xA0 with last_o = 1; afterwards state = RUN and rdy_o = 1.
REQ-027 Hold rdy_i = 0 for 5 cycles with fill = 12 -> data_o, vld_o stable and rdy_o = 0; release -> one word popped, fill = 4, rdy_o = 1.
REQ-028 clr_i asserted in DRAIN with fill = 10 -> next cycle vld_o = 0, rdy_o = 1, fill = 0; a new stream then packs correctly.
REQ-029 Random codeword/length stream with random backpressure, checked against a bit-queue reference model -> bit-exact output and last_o on the final word.
